// File: rtl/fan_pkg.sv
// Shared types for the fan gear sequencer slice.
// Optional sleep-warning blink is enabled with FAN_SLEEP_WARN_EN.
package fan_pkg;

    typedef enum logic [1:0] {
        FAN_OFF  = 2'b00,
        FAN_LOW  = 2'b01,
        FAN_MID  = 2'b10,
        FAN_HIGH = 2'b11
    } fan_state_t;

    typedef enum logic [1:0] {
        SEQ_OFF,
        SEQ_RAMP,
        SEQ_RUN
    } seq_fsm_t;

    localparam int TICK_HZ = 100;

endpackage

// File: rtl/fan_sleep_timer.sv
// Button-programmed sleep countdown with single-cycle expiry pulse.
// Optional warn blink output when FAN_SLEEP_WARN_EN is defined.
module fan_sleep_timer
    import fan_pkg::*;
#(
    parameter int STEP_S    = 60,
    parameter int MAX_STEPS = 4,
    parameter int RW        = $clog2(STEP_S * MAX_STEPS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick_1s,
    input  logic          press,
    input  logic          enable,
    output logic          expire,
    output logic          active,
    output logic [RW-1:0] remain,
    output logic          force_off
`ifdef FAN_SLEEP_WARN_EN
    ,
    output logic          warn
`endif
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    logic [SW-1:0] steps;
    logic [RW-1:0] reload;

    assign reload = RW'((int'(steps) + 1) * STEP_S);

    // A press in the same cycle as the last tick reloads instead of expiring.
    assign expire = enable && !press && active && tick_1s
                 && remain == RW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            steps     <= '0;
            remain    <= '0;
            active    <= 1'b0;
            force_off <= 1'b0;
        end else begin
            force_off <= expire;
            if (!enable) begin
                steps  <= '0;
                remain <= '0;
                active <= 1'b0;
            end else if (press) begin
                if (int'(steps) == MAX_STEPS) begin
                    steps  <= '0;
                    remain <= '0;
                    active <= 1'b0;
                end else begin
                    steps  <= steps + 1'b1;
                    remain <= reload;
                    active <= 1'b1;
                end
            end else if (active && tick_1s && remain != '0) begin
                remain <= remain - 1'b1;
                if (remain == RW'(1)) begin
                    steps  <= '0;
                    active <= 1'b0;
                end
            end
        end
    end

`ifdef FAN_SLEEP_WARN_EN
    logic in_win;
    logic blink;

    assign in_win = active && int'(remain) <= 10;
    assign warn   = in_win && !blink;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink <= 1'b0;
        end else if (!in_win) begin
            blink <= 1'b0;
        end else if (tick_1s) begin
            blink <= !blink;
        end
    end
`endif

endmodule

// File: rtl/fan_gear_sequencer.sv
// Fan gear soft-start sequencer with sleep timer.
// Define FAN_SLEEP_WARN_EN to add the sleep_warn blink output.
module fan_gear_sequencer
    import fan_pkg::*;
#(
    parameter int RAMP_S          = 1,
    parameter int SLEEP_STEP_S    = 60,
    parameter int SLEEP_MAX_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1s,
    input  logic [1:0] req_state,
    input  logic       battery_empty,
    input  logic       sleep_press,
    output logic [1:0] state_out,
    output logic       sleep_active,
    output logic [$clog2(SLEEP_STEP_S*SLEEP_MAX_STEPS+1)-1:0] sleep_remain,
    output logic       force_off
`ifdef FAN_SLEEP_WARN_EN
    ,
    output logic       sleep_warn
`endif
);

    localparam int RW = $clog2(SLEEP_STEP_S * SLEEP_MAX_STEPS + 1);
    localparam int CW = $clog2(RAMP_S + 1);

    fan_state_t    target;
    fan_state_t    target_q;
    fan_state_t    gear;
    seq_fsm_t      fsm;
    logic [CW-1:0] ramp_cnt;
    logic          expire;

    assign target    = battery_empty ? FAN_OFF : fan_state_t'(req_state);
    assign state_out = gear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= SEQ_OFF;
            gear     <= FAN_OFF;
            target_q <= FAN_OFF;
            ramp_cnt <= '0;
        end else begin
            target_q <= target;
            if (expire) begin
                fsm      <= SEQ_OFF;
                gear     <= FAN_OFF;
                ramp_cnt <= '0;
            end else if (target < gear) begin
                gear     <= target;
                ramp_cnt <= '0;
                fsm      <= (target == FAN_OFF) ? SEQ_OFF : SEQ_RUN;
            end else begin
                unique case (fsm)
                    SEQ_OFF: begin
                        if (target != FAN_OFF) begin
                            gear     <= FAN_LOW;
                            fsm      <= SEQ_RAMP;
                            ramp_cnt <= '0;
                        end
                    end
                    SEQ_RAMP: begin
                        if (gear == target) begin
                            fsm      <= SEQ_RUN;
                            ramp_cnt <= '0;
                        end else if (tick_1s) begin
                            if (int'(ramp_cnt) == RAMP_S - 1) begin
                                gear     <= fan_state_t'(gear + 2'd1);
                                ramp_cnt <= '0;
                            end else begin
                                ramp_cnt <= ramp_cnt + 1'b1;
                            end
                        end
                    end
                    SEQ_RUN: begin
                        if (target > gear) begin
                            fsm      <= SEQ_RAMP;
                            ramp_cnt <= '0;
                        end
                    end
                    default: fsm <= SEQ_OFF;
                endcase
                // A lowered (but still higher) target restarts the step wait.
                if (target < target_q) ramp_cnt <= '0;
            end
        end
    end

    fan_sleep_timer #(
        .STEP_S    (SLEEP_STEP_S),
        .MAX_STEPS (SLEEP_MAX_STEPS),
        .RW        (RW)
    ) u_sleep (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1s   (tick_1s),
        .press     (sleep_press),
        .enable    (target != FAN_OFF),
        .expire    (expire),
        .active    (sleep_active),
        .remain    (sleep_remain),
        .force_off (force_off)
`ifdef FAN_SLEEP_WARN_EN
        ,
        .warn      (sleep_warn)
`endif
    );

endmodule

// File: tb/tb_fan_gear_sequencer.sv
// Self-checking bench for fan_gear_sequencer: directed cases plus
// randomized traffic against a behavioural model.
module tb_fan_gear_sequencer;

    localparam int RAMP_S = 1;
    localparam int STEP   = 3;
    localparam int MAXS   = 4;
    localparam int RW     = $clog2(STEP * MAXS + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          tick = 1'b0;
    logic [1:0]    req = 2'd0;
    logic          be = 1'b0;
    logic          press = 1'b0;
    logic [1:0]    state_out;
    logic          sleep_active;
    logic [RW-1:0] sleep_remain;
    logic          force_off;

    int n_cmp = 0;
    int n_bad = 0;

    int m_gear, m_rc, m_prev_tgt, m_steps, m_remain, m_fo;

    always #5 clk = ~clk;

    fan_gear_sequencer #(
        .RAMP_S          (RAMP_S),
        .SLEEP_STEP_S    (STEP),
        .SLEEP_MAX_STEPS (MAXS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1s       (tick),
        .req_state     (req),
        .battery_empty (be),
        .sleep_press   (press),
        .state_out     (state_out),
        .sleep_active  (sleep_active),
        .sleep_remain  (sleep_remain),
        .force_off     (force_off)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_gear = 0; m_rc = 0; m_prev_tgt = 0;
        m_steps = 0; m_remain = 0; m_fo = 0;
    endtask

    // Behavioural reference: gear ramps one step per RAMP_S ticks,
    // drops immediately, sleep timer counts down in whole seconds.
    task automatic model_step(input bit t, input int r, input bit b,
                              input bit p);
        int  tgt;
        int  old;
        bit  ex;
        tgt = b ? 0 : r;
        ex  = (tgt != 0) && !p && m_steps > 0 && t && m_remain == 1;
        if (tgt == 0) begin
            m_steps = 0; m_remain = 0;
        end else if (p) begin
            if (m_steps == MAXS) begin
                m_steps = 0; m_remain = 0;
            end else begin
                m_steps++;
                m_remain = m_steps * STEP;
            end
        end else if (m_steps > 0 && t) begin
            m_remain--;
            if (m_remain == 0) m_steps = 0;
        end
        m_fo = ex ? 1 : 0;
        old = m_gear;
        if (ex) m_gear = 0;
        else if (tgt < m_gear) m_gear = tgt;
        else if (m_gear == 0 && tgt > 0) m_gear = 1;
        else if (m_gear < tgt && t) begin
            m_rc++;
            if (m_rc >= RAMP_S) m_gear++;
        end
        if (m_gear != old || tgt < m_prev_tgt) m_rc = 0;
        m_prev_tgt = tgt;
    endtask

    task automatic cyc(input bit t, input logic [1:0] r, input bit b,
                       input bit p);
        tick = t; req = r; be = b; press = p;
        @(posedge clk);
        model_step(t, int'(r), b, p);
        #1;
        check("state_out", state_out, m_gear);
        check("sleep_active", sleep_active, m_steps > 0);
        check("sleep_remain", sleep_remain, m_remain);
        check("force_off", force_off, m_fo);
    endtask

    initial begin
        bit         t, b, p;
        logic [1:0] r;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", state_out, 0);
        check("rst_active", sleep_active, 0);
        check("rst_remain", sleep_remain, 0);
        check("rst_force", force_off, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp up 00 -> 11
        cyc(0, 0, 0, 0);
        cyc(0, 3, 0, 0); check("t1_low", state_out, 1);
        cyc(0, 3, 0, 0); check("t1_hold", state_out, 1);
        cyc(1, 3, 0, 0); check("t1_mid", state_out, 2);
        cyc(0, 3, 0, 0);
        cyc(1, 3, 0, 0); check("t1_high", state_out, 3);
        cyc(0, 3, 0, 0);
        cyc(1, 3, 0, 0); check("t1_run", state_out, 3);

        // Immediate drop
        cyc(0, 1, 0, 0); check("t2_drop", state_out, 1);

        // Battery mid-ramp with sleep armed
        cyc(0, 3, 0, 0);
        cyc(1, 3, 0, 0); check("t3_mid", state_out, 2);
        cyc(0, 3, 0, 1); check("t3_armed", sleep_active, 1);
        cyc(0, 3, 1, 0);
        check("t3_off", state_out, 0);
        check("t3_disarm", sleep_active, 0);
        check("t3_nofo", force_off, 0);
        cyc(0, 0, 0, 0);

        // Sleep countdown and expiry
        cyc(0, 2, 0, 0);
        cyc(1, 2, 0, 0);
        cyc(0, 2, 0, 1); check("t4_r3", sleep_remain, 3);
        cyc(0, 2, 0, 1); check("t4_r6", sleep_remain, 6);
        for (int k = 1; k <= 5; k++) begin
            cyc(1, 2, 0, 0);
            check("t4_count", sleep_remain, 6 - k);
            cyc(0, 2, 0, 0);
        end
        cyc(1, 2, 0, 0);
        check("t4_fo", force_off, 1);
        check("t4_off", state_out, 0);
        check("t4_inact", sleep_active, 0);
        cyc(0, 0, 0, 0); check("t4_fo_once", force_off, 0);

        // Cancel after max steps
        cyc(0, 2, 0, 0);
        for (int k = 1; k <= MAXS; k++) begin
            cyc(0, 2, 0, 1);
            check("t5_step", sleep_remain, k * STEP);
        end
        cyc(0, 2, 0, 1);
        check("t5_cancel", sleep_remain, 0);
        check("t5_inact", sleep_active, 0);

        // Press in the expiry cycle reloads
        cyc(0, 2, 0, 1);
        cyc(1, 2, 0, 0);
        cyc(1, 2, 0, 0); check("t5_r1", sleep_remain, 1);
        cyc(1, 2, 0, 1);
        check("t5_reload", sleep_remain, 2 * STEP);
        check("t5_nofo", force_off, 0);

        // Randomized traffic; level changes kept off tick cycles
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 3) == 0);
            r = req;
            b = be;
            if (!t && $urandom_range(0, 19) == 0) r = 2'($urandom_range(0, 3));
            if (!t && $urandom_range(0, 59) == 0) b = ~be;
            p = ($urandom_range(0, 15) == 0);
            cyc(t, r, b, p);
        end

        // Async reset mid-ramp, between clock edges
        cyc(0, 0, 0, 0);
        cyc(0, 3, 0, 0);
        cyc(0, 3, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_state", state_out, 0);
        check("t6_active", sleep_active, 0);
        check("t6_remain", sleep_remain, 0);
        check("t6_force", force_off, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
